tff: RTL and testbench

TFF -- requirements
Module: tff

---
 rtl/tff.sv | 54 +++++
 tb/tb_tff.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tff.sv
// Toggle flip-flop with asynchronous active-low clear and synchronous preset.
// q is the single state bit; p is its combinational complement, so the two
// outputs stay complementary even while clr is holding the flop in reset.
module tff #(
  parameter logic RESET_Q  = 1'b0,
  parameter logic PRESET_Q = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic pre,
  input  logic t,
  output logic q,
  output logic p
);

  logic r_q;

  // State bit: clr wins asynchronously, then preset, then toggle, else hold.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= RESET_Q;
    end else if (pre) begin
      r_q <= PRESET_Q;
    end else if (t) begin
      r_q <= ~r_q;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;
  assign p = ~r_q;

`ifndef SYNTHESIS
  // Outputs are always complementary.
  a_p_is_not_q : assert property (@(posedge clk) p == ~q);

  // While clear is held, the state sits at its reset value.
  a_reset_value : assert property (@(posedge clk) !clr |-> (q == RESET_Q));

  // Preset has priority over toggle.
  a_preset : assert property (@(posedge clk) disable iff (!clr)
    pre |=> (q == PRESET_Q));

  // Toggle inverts the state on the following edge.
  a_toggle : assert property (@(posedge clk) disable iff (!clr)
    (!pre && t) |=> (q != $past(q)));

  // With neither preset nor toggle the state is held.
  a_hold : assert property (@(posedge clk) disable iff (!clr)
    (!pre && !t) |=> $stable(q));
`endif

endmodule

// File: tb/tb_tff.sv
// Self-checking bench for tff: directed reset/toggle/preset sequences, a small
// vector table, and a randomized run checked against a parity-based model.
module tb_tff;

  localparam logic RESET_Q  = 1'b0;
  localparam logic PRESET_Q = 1'b1;

  logic clk;
  logic clr;
  logic pre;
  logic t;
  logic q;
  logic p;

  int total;
  int bad;

  tff #(
    .RESET_Q  (RESET_Q),
    .PRESET_Q (PRESET_Q)
  ) dut (
    .clk (clk),
    .clr (clr),
    .pre (pre),
    .t   (t),
    .q   (q),
    .p   (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector record: inputs applied before an edge, q expected after it.
  typedef struct {
    logic pre;
    logic t;
    logic exp_q;
  } vec_t;

  // Reference model: q = base value (last reset/preset) XOR parity of the
  // number of toggles seen since then.
  logic ref_base;
  int   ref_toggles;

  function automatic logic ref_q();
    return ref_base ^ ref_toggles[0];
  endfunction

  task automatic model_reset();
    ref_base    = RESET_Q;
    ref_toggles = 0;
  endtask

  task automatic model_edge(input logic in_pre, input logic in_t);
    if (in_pre) begin
      ref_base    = PRESET_Q;
      ref_toggles = 0;
    end else if (in_t) begin
      ref_toggles = ref_toggles + 1;
    end
  endtask

  task automatic check_qp(input string name, input logic exp_q);
    total = total + 1;
    if (q !== exp_q) begin
      bad = bad + 1;
      $display("FAIL %s q: got %b want %b at %0t", name, q, exp_q, $time);
    end
    total = total + 1;
    if (p !== ~exp_q) begin
      bad = bad + 1;
      $display("FAIL %s p: got %b want %b at %0t", name, p, ~exp_q, $time);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[11];

  initial begin
    total = 0;
    bad   = 0;
    model_reset();

    vecs[0]  = '{pre: 1'b1, t: 1'b1, exp_q: 1'b1};
    vecs[1]  = '{pre: 1'b0, t: 1'b0, exp_q: 1'b1};
    vecs[2]  = '{pre: 1'b0, t: 1'b0, exp_q: 1'b1};
    vecs[3]  = '{pre: 1'b0, t: 1'b1, exp_q: 1'b0};
    vecs[4]  = '{pre: 1'b1, t: 1'b0, exp_q: 1'b1};
    vecs[5]  = '{pre: 1'b1, t: 1'b0, exp_q: 1'b1};
    vecs[6]  = '{pre: 1'b0, t: 1'b1, exp_q: 1'b0};
    vecs[7]  = '{pre: 1'b1, t: 1'b1, exp_q: 1'b1};
    vecs[8]  = '{pre: 1'b0, t: 1'b1, exp_q: 1'b0};
    vecs[9]  = '{pre: 1'b0, t: 1'b1, exp_q: 1'b1};
    vecs[10] = '{pre: 1'b0, t: 1'b0, exp_q: 1'b1};

    // Clear held with preset asserted for 100 ns: preset must be ignored.
    clr = 1'b0;
    pre = 1'b1;
    t   = 1'b0;
    #2;
    for (int i = 0; i < 20; i++) begin
      check_qp("reset_hold", 1'b0);
      #5;
    end

    // Release clear between edges, then toggle over four edges.
    @(negedge clk);
    clr = 1'b1;
    pre = 1'b0;
    t   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp;
      exp = (i % 2 == 0) ? 1'b1 : 1'b0;
      edge_wait();
      check_qp("toggle4", exp);
    end

    // Vector table (starts from q=0).
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      pre = vecs[i].pre;
      t   = vecs[i].t;
      edge_wait();
      check_qp($sformatf("vec%0d", i), vecs[i].exp_q);
    end

    // q is 1 here; clear between edges must act before the next rising edge.
    @(negedge clk);
    pre = 1'b1;
    t   = 1'b1;
    #2;
    clr = 1'b0;
    #1;
    check_qp("async_clr", 1'b0);
    edge_wait();
    check_qp("clr_overrides", 1'b0);

    // Release clear at a rising edge with t=1: that edge must not toggle.
    @(negedge clk);
    pre = 1'b0;
    t   = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b1;
    check_qp("release_edge", 1'b0);
    edge_wait();
    check_qp("first_after_release", 1'b1);

    // Randomized run with occasional mid-run clears.
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_qp("rand_init", ref_q());
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        pre = $urandom_range(0, 1) == 1;
        t   = $urandom_range(0, 1) == 1;
        #1;
        clr = 1'b0;
        model_reset();
        #1;
        check_qp("rand_clr", ref_q());
        edge_wait();
        check_qp("rand_clr_edge", ref_q());
      end else begin
        clr = 1'b1;
        pre = $urandom_range(0, 5) == 0;
        t   = $urandom_range(0, 1) == 1;
        edge_wait();
        model_edge(pre, t);
        check_qp("rand", ref_q());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
